ls_unit: RTL

Load/store execution unit directly downstream of the load/store reservation station. It consumes the station's held entry, waits until both operands are unlocked, arbitrates for the byte-wide memory bus, and performs the access one byte per cycle. It then broadcasts the result (value, destination tag, register address) on the common data bus and tells the station to release its entry.

---
 rtl/ls_unit_if.sv | 27 ++
 rtl/ls_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ls_unit_if.sv
// Byte-wide memory bus between the load/store unit and the bus arbiter/memory.
interface ls_unit_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    modport master (
        output mem_req,
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_gnt,
        input  mem_din
    );

    modport slave (
        input  mem_req,
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_gnt,
        output mem_din
    );
endinterface

// File: rtl/ls_unit.sv
// Load/store execution unit: takes the reservation station's held entry, arbitrates for the
// byte-wide bus, moves one byte per cycle and broadcasts the result on the common data bus.
module ls_unit (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rs_busy,
    input  logic [2:0]       rs_op,
    input  logic [31:0]      rs_offset,
    input  logic [3:0]       rs_tagx,
    input  logic [3:0]       rs_tagy,
    input  logic [3:0]       rs_tagw,
    input  logic [31:0]      rs_datax,
    input  logic [31:0]      rs_datay,
    input  logic [4:0]       rs_target,
    output logic             busy_ls,
    output logic             ls_valid,
    output logic [31:0]      ls_data,
    output logic [3:0]       ls_tag,
    output logic [4:0]       ls_target,
    ls_unit_if.master        mem
);

    // Shared encodings for sinst_t and the operand-ready tag.
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd3;
    localparam logic [2:0] LHU = 3'd4;
    localparam logic [2:0] SB  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SW  = 3'd7;
    localparam logic [3:0] UNLOCKED = 4'hF;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic [3:0]  tag_q, tag_d;
    logic [4:0]  target_q, target_d;

    logic        req_idle;
    logic        step;
    logic [2:0]  len;
    logic [2:0]  cap_idx;

    function automatic logic is_store(input logic [2:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [2:0] op_len(input logic [2:0] op);
        case (op)
            LB, LBU, SB: return 3'd1;
            LH, LHU, SH: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    assign ls_tag    = tag_q;
    assign ls_target = target_q;

    // Next-state, datapath capture and bus/CDB outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        op_d         = op_q;
        sdata_d      = sdata_q;
        ldata_d      = ldata_q;
        tag_d        = tag_q;
        target_d     = target_q;
        mem.mem_req  = 1'b0;
        mem.mem_wr   = 1'b0;
        mem.mem_a    = '0;
        mem.mem_dout = '0;
        busy_ls      = 1'b1;
        ls_valid     = 1'b0;
        ls_data      = '0;
        req_idle     = rs_busy && (rs_tagx == UNLOCKED)
                       && (!is_store(rs_op) || (rs_tagy == UNLOCKED));
        step         = rdy && mem.mem_gnt;
        len          = op_len(op_q);
        cap_idx      = cnt_q - 3'd1;

        unique case (state_q)
            StIdle: begin
                mem.mem_req = req_idle;
                if (req_idle && step) begin
                    addr_d   = rs_datax + rs_offset;
                    op_d     = rs_op;
                    sdata_d  = rs_datay;
                    tag_d    = rs_tagw;
                    target_d = rs_target;
                    cnt_d    = '0;
                    ldata_d  = '0;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                mem.mem_req = 1'b1;
                mem.mem_a   = addr_q + {29'd0, cnt_q};
                if (is_store(op_q)) begin
                    mem.mem_dout = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem.mem_wr   = step;
                    if (step) begin
                        if (cnt_q == len - 3'd1) state_d = StDone;
                        else                     cnt_d   = cnt_q + 3'd1;
                    end
                end else if (step) begin
                    // Read data lags its address by one cycle, so byte k lands at cnt k+1.
                    if (cnt_q != 3'd0) ldata_d[{cap_idx[1:0], 3'b000} +: 8] = mem.mem_din;
                    if (cnt_q == len) state_d = StDone;
                    else              cnt_d   = cnt_q + 3'd1;
                end
            end
            StDone: begin
                busy_ls  = 1'b0;
                ls_valid = rdy;
                case (op_q)
                    LB:      ls_data = {{24{ldata_q[7]}}, ldata_q[7:0]};
                    LH:      ls_data = {{16{ldata_q[15]}}, ldata_q[15:0]};
                    LW:      ls_data = ldata_q;
                    LBU:     ls_data = {24'd0, ldata_q[7:0]};
                    LHU:     ls_data = {16'd0, ldata_q[15:0]};
                    default: ls_data = '0;
                endcase
                if (rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-operand registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            op_q     <= LB;
            sdata_q  <= '0;
            ldata_q  <= '0;
            tag_q    <= UNLOCKED;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            sdata_q  <= sdata_d;
            ldata_q  <= ldata_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule
